// File: rtl/bus_bridge_pkg.sv
// Shared definitions for both ends of the UART bus bridge: frame layout,
// controller state encoding and transaction mode values.
package bus_bridge_pkg;

    localparam int ADDR_LSB = 0;

    localparam logic MODE_WRITE = 1'b1;
    localparam logic MODE_READ  = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // The frame is {mode, wdata, addr}, so the upper offsets follow from the widths.
    function automatic int wdata_lsb(input int addr_width);
        return addr_width;
    endfunction

    function automatic int mode_bit(input int addr_width, input int data_width);
        return addr_width + data_width;
    endfunction

endpackage

// File: rtl/bus_bridge_master_ctrl_if.sv
// UART-side and master-port-side signals of the remote bridge controller.
// master = the controller, slave = the UART / master port surroundings.
interface bus_bridge_master_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
);
    localparam int FRAME_WIDTH = DATA_WIDTH + ADDR_WIDTH + 1;

    logic                   u_rx_ready;
    logic [FRAME_WIDTH-1:0] u_rx_data;
    logic                   u_tx_busy;
    logic                   u_tx_en;
    logic [DATA_WIDTH-1:0]  u_tx_data;
    logic                   mp_valid;
    logic                   mp_ready;
    logic                   mp_mode;
    logic [ADDR_WIDTH-1:0]  mp_addr;
    logic [DATA_WIDTH-1:0]  mp_wdata;
    logic                   mp_done;
    logic [DATA_WIDTH-1:0]  mp_rdata;
    logic [7:0]             drop_cnt;

    modport master (
        input  u_rx_ready, u_rx_data, u_tx_busy, mp_ready, mp_done, mp_rdata,
        output u_tx_en, u_tx_data, mp_valid, mp_mode, mp_addr, mp_wdata, drop_cnt
    );

    modport slave (
        output u_rx_ready, u_rx_data, u_tx_busy, mp_ready, mp_done, mp_rdata,
        input  u_tx_en, u_tx_data, mp_valid, mp_mode, mp_addr, mp_wdata, drop_cnt
    );

endinterface

// File: rtl/bb_cmd_hold.sv
// One-deep command frame buffer with a saturating count of frames lost to overflow.
// A push in the same cycle as a pop is accepted.
module bb_cmd_hold #(
    parameter int FRAME_WIDTH = 21
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [FRAME_WIDTH-1:0] i_frame,
    input  logic                   i_pop,
    output logic                   o_full,
    output logic [FRAME_WIDTH-1:0] o_frame,
    output logic [7:0]             o_drop_cnt
);

    logic                   r_full;
    logic [FRAME_WIDTH-1:0] r_frame;
    logic [7:0]             r_drop_cnt;
    logic                   w_drop;

    assign w_drop = i_push && r_full && !i_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full     <= 1'b0;
            r_frame    <= '0;
            r_drop_cnt <= 8'd0;
        end else begin
            if (i_push && !w_drop) begin
                r_frame <= i_frame;
            end
            if (i_push) begin
                r_full <= 1'b1;
            end else if (i_pop) begin
                r_full <= 1'b0;
            end
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign o_full     = r_full;
    assign o_frame    = r_frame;
    assign o_drop_cnt = r_drop_cnt;

endmodule

// File: rtl/bus_bridge_master_ctrl.sv
// Remote end of the UART bus bridge: turns received frames into master-port
// transactions and returns read data over UART TX. BB_RD_TIMEOUT_EN adds a transaction timeout.
//
//   state    | meaning
//   ST_IDLE  | no transaction; pops the hold buffer when it is full
//   ST_ISSUE | mp_valid held with stable fields until mp_ready
//   ST_WAIT  | request accepted, waiting for mp_done
//   ST_RESP  | read data latched, waiting for UART TX to be free
module bus_bridge_master_ctrl
    import bus_bridge_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    bus_bridge_master_ctrl_if.master bus
);

    localparam int FRAME_WIDTH = DATA_WIDTH + ADDR_WIDTH + 1;
    localparam int WDATA_LSB   = wdata_lsb(ADDR_WIDTH);
    localparam int MODE_BIT    = mode_bit(ADDR_WIDTH, DATA_WIDTH);

    state_t                  r_state;
    logic                    r_mp_valid;
    logic                    r_mp_mode;
    logic [ADDR_WIDTH-1:0]   r_mp_addr;
    logic [DATA_WIDTH-1:0]   r_mp_wdata;
    logic                    r_tx_en;
    logic [DATA_WIDTH-1:0]   r_tx_data;

    logic                    w_full;
    logic                    w_pop;
    logic [FRAME_WIDTH-1:0]  w_frame;
    logic [7:0]              w_drop_cnt;
    logic                    w_accept;
    logic                    w_finish;
    logic                    w_expire;

    bb_cmd_hold #(
        .FRAME_WIDTH (FRAME_WIDTH)
    ) u_hold (
        .clk        (clk),
        .rst        (rst),
        .i_push     (bus.u_rx_ready),
        .i_frame    (bus.u_rx_data),
        .i_pop      (w_pop),
        .o_full     (w_full),
        .o_frame    (w_frame),
        .o_drop_cnt (w_drop_cnt)
    );

    assign w_pop    = (r_state == ST_IDLE) && w_full;
    assign w_accept = (r_state == ST_ISSUE) && bus.mp_ready;
    // A ready coinciding with done is taken as acceptance followed by completion.
    assign w_finish = ((r_state == ST_WAIT) || w_accept) && bus.mp_done;

`ifdef BB_RD_TIMEOUT_EN
    localparam int                TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0]  TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             w_in_txn;

    assign w_in_txn = (r_state == ST_ISSUE) || (r_state == ST_WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= TMO_LOAD;
        end else if (!w_in_txn || w_accept) begin
            r_tmo_cnt <= TMO_LOAD;
        end else if (r_tmo_cnt != '0) begin
            r_tmo_cnt <= r_tmo_cnt - TMO_W'(1);
        end
    end

    assign w_expire = w_in_txn && (r_tmo_cnt == '0) && !w_accept && !w_finish;
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
    assign w_expire     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_mp_valid <= 1'b0;
            r_mp_mode  <= 1'b0;
            r_mp_addr  <= '0;
            r_mp_wdata <= '0;
            r_tx_en    <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_tx_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_full) begin
                        r_mp_mode  <= w_frame[MODE_BIT];
                        r_mp_addr  <= w_frame[ADDR_LSB +: ADDR_WIDTH];
                        r_mp_wdata <= w_frame[WDATA_LSB +: DATA_WIDTH];
                        r_mp_valid <= 1'b1;
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE, ST_WAIT: begin
                    if (w_finish || w_expire) begin
                        r_mp_valid <= 1'b0;
                        if (r_mp_mode == MODE_READ) begin
                            r_tx_data <= w_finish ? bus.mp_rdata : '1;
                            r_state   <= ST_RESP;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (w_accept) begin
                        r_mp_valid <= 1'b0;
                        r_state    <= ST_WAIT;
                    end
                end
                ST_RESP: begin
                    if (!bus.u_tx_busy) begin
                        r_tx_en <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.mp_valid  = r_mp_valid;
    assign bus.mp_mode   = r_mp_mode;
    assign bus.mp_addr   = r_mp_addr;
    assign bus.mp_wdata  = r_mp_wdata;
    assign bus.u_tx_en   = r_tx_en;
    assign bus.u_tx_data = r_tx_data;
    assign bus.drop_cnt  = w_drop_cnt;

endmodule

// File: tb/tb_bus_bridge_master_ctrl.sv
// Bench for bus_bridge_master_ctrl: transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_bus_bridge_master_ctrl;

    localparam int DW  = 8;
    localparam int AW  = 12;
    localparam int TMO = 16;

    logic clk;
    logic rst;

    bus_bridge_master_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    bus_bridge_master_ctrl #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int n_tx_en = 0;
    bit cmp_on = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct packed {
        logic          mode;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } frm_t;

    frm_t          hq[$];
    bit            m_valid, m_flight, m_resp, m_tx_en, m_mode;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_tx_data;
    int            m_drop;
    int            m_phase;

    function automatic frm_t split(input logic [DW+AW:0] f);
        frm_t r;
        r.mode  = f[DW+AW];
        r.wdata = f[AW +: DW];
        r.addr  = f[AW-1:0];
        return r;
    endfunction

    task automatic model_reset();
        hq.delete();
        m_valid = 0; m_flight = 0; m_resp = 0; m_tx_en = 0; m_mode = 0;
        m_addr = '0; m_wdata = '0; m_tx_data = '0; m_drop = 0; m_phase = 0;
    endtask

    task automatic model_tick();
        bit   active, pop, accept, finish, expire;
        frm_t f;
        active  = m_valid || m_flight || m_resp;
        pop     = (hq.size() != 0) && !active;
        m_tx_en = 0;
        if (m_resp && !bus.u_tx_busy) begin
            m_tx_en = 1;
            m_resp  = 0;
        end
        accept = m_valid && bus.mp_ready;
        finish = (accept || m_flight) && bus.mp_done;
        expire = 0;
`ifdef BB_RD_TIMEOUT_EN
        if ((m_valid || m_flight) && !accept && !finish) begin
            if (m_phase == TMO - 1) expire = 1;
            else m_phase++;
        end else begin
            m_phase = 0;
        end
`endif
        if (finish || expire) begin
            m_valid  = 0;
            m_flight = 0;
            if (!m_mode) begin
                m_tx_data = finish ? bus.mp_rdata : 8'hFF;
                m_resp    = 1;
            end
        end else if (accept) begin
            m_valid  = 0;
            m_flight = 1;
        end
        if (pop) begin
            f       = hq.pop_front();
            m_mode  = f.mode;
            m_addr  = f.addr;
            m_wdata = f.wdata;
            m_valid = 1;
            m_phase = 0;
        end
        if (bus.u_rx_ready) begin
            if (hq.size() == 0) hq.push_back(split(bus.u_rx_data));
            else if (m_drop < 255) m_drop++;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else model_tick();
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("mp_valid", bus.mp_valid, m_valid);
            chk("mp_mode", bus.mp_mode, m_mode);
            chk("mp_addr", bus.mp_addr, m_addr);
            if (m_mode) chk("mp_wdata", bus.mp_wdata, m_wdata);
            chk("u_tx_en", bus.u_tx_en, m_tx_en);
            chk("u_tx_data", bus.u_tx_data, m_tx_data);
            chk("drop_cnt", bus.drop_cnt, m_drop);
        end
        if (bus.u_tx_en === 1'b1) n_tx_en++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW+AW:0] f);
        bus.u_rx_ready = 1'b1;
        bus.u_rx_data  = f;
        tick();
        bus.u_rx_ready = 1'b0;
    endtask

    task automatic ready_pulse();
        bus.mp_ready = 1'b1;
        tick();
        bus.mp_ready = 1'b0;
    endtask

    task automatic done_pulse(input logic [DW-1:0] d);
        bus.mp_done  = 1'b1;
        bus.mp_rdata = d;
        tick();
        bus.mp_done  = 1'b0;
    endtask

    int tx0;

    initial begin
        rst            = 1'b1;
        bus.u_rx_ready = 1'b0;
        bus.u_rx_data  = '0;
        bus.u_tx_busy  = 1'b0;
        bus.mp_ready   = 1'b0;
        bus.mp_done    = 1'b0;
        bus.mp_rdata   = '0;
        cmp_on         = 1;
        tick(2);
        chk("rst_valid", bus.mp_valid, 0);
        chk("rst_addr", bus.mp_addr, 0);
        chk("rst_wdata", bus.mp_wdata, 0);
        chk("rst_tx_en", bus.u_tx_en, 0);
        chk("rst_drop", bus.drop_cnt, 0);
        rst = 1'b0;
        tick(2);

        // write: fields held while ready is withheld, no UART response
        send(21'h1A5123);
        tick();
        chk("t1_valid", bus.mp_valid, 1);
        chk("t1_mode", bus.mp_mode, 1);
        chk("t1_addr", bus.mp_addr, 12'h123);
        chk("t1_wdata", bus.mp_wdata, 8'hA5);
        tick(3);
        chk("t1_hold_valid", bus.mp_valid, 1);
        chk("t1_hold_addr", bus.mp_addr, 12'h123);
        ready_pulse();
        chk("t1_valid_drop", bus.mp_valid, 0);
        tx0 = n_tx_en;
        done_pulse(8'h00);
        tick(4);
        chk("t1_no_tx", n_tx_en - tx0, 0);
        chk("t1_keep_addr", bus.mp_addr, 12'h123);

        // read returns data over UART
        send(21'h000456);
        tick();
        chk("t2_valid", bus.mp_valid, 1);
        chk("t2_mode", bus.mp_mode, 0);
        chk("t2_addr", bus.mp_addr, 12'h456);
        ready_pulse();
        tx0 = n_tx_en;
        done_pulse(8'h3C);
        tick();
        chk("t2_tx_en", bus.u_tx_en, 1);
        chk("t2_tx_data", bus.u_tx_data, 8'h3C);
        tick();
        chk("t2_tx_en_low", bus.u_tx_en, 0);
        chk("t2_one_pulse", n_tx_en - tx0, 1);

        // done while idle is ignored
        done_pulse(8'hEE);
        tick(3);
        chk("idle_done_data", bus.u_tx_data, 8'h3C);
        chk("idle_done_valid", bus.mp_valid, 0);

        // ready and done in the same cycle
        send(21'h000222);
        tick();
        bus.mp_ready = 1'b1;
        bus.mp_done  = 1'b1;
        bus.mp_rdata = 8'h99;
        tick();
        bus.mp_ready = 1'b0;
        bus.mp_done  = 1'b0;
        chk("rd_same_valid", bus.mp_valid, 0);
        tick();
        chk("rd_same_tx_en", bus.u_tx_en, 1);
        chk("rd_same_data", bus.u_tx_data, 8'h99);
        tick(2);

        // three frames during a pending read; fourth lands on the pop cycle
        send(21'h000010);
        tick();
        ready_pulse();
        send(21'h177020);
        send(21'h000030);
        chk("t3_drop", bus.drop_cnt, 1);
        done_pulse(8'h5A);
        tick();
        chk("t3_tx_en", bus.u_tx_en, 1);
        chk("t3_tx_data", bus.u_tx_data, 8'h5A);
        send(21'h000040);
        chk("t3_second_valid", bus.mp_valid, 1);
        chk("t3_second_addr", bus.mp_addr, 12'h020);
        chk("t3_second_wdata", bus.mp_wdata, 8'h77);
        chk("t3_drop_pushpop", bus.drop_cnt, 1);
        ready_pulse();
        done_pulse(8'h00);
        tick();
        chk("t3_fourth_addr", bus.mp_addr, 12'h040);
        chk("t3_fourth_mode", bus.mp_mode, 0);
        ready_pulse();
        done_pulse(8'h81);
        tick();
        chk("t3_fourth_data", bus.u_tx_data, 8'h81);
        tick(3);
        chk("t3_third_dropped", bus.mp_valid, 0);

        // response held off by a busy UART
        bus.u_tx_busy = 1'b1;
        send(21'h000111);
        tick();
        ready_pulse();
        tx0 = n_tx_en;
        done_pulse(8'hC7);
        tick(49);
        chk("t4_held", n_tx_en - tx0, 0);
        bus.u_tx_busy = 1'b0;
        tick();
        chk("t4_tx_en", bus.u_tx_en, 1);
        chk("t4_tx_data", bus.u_tx_data, 8'hC7);
        tick(3);
        chk("t4_once", n_tx_en - tx0, 1);

        // flood during a read to saturate drop_cnt, then reset in WAIT
        send(21'h000333);
        tick();
        ready_pulse();
        for (int i = 0; i < 300; i++) begin
            bus.u_rx_ready = 1'b1;
            bus.u_rx_data  = 21'h100000 | 21'(i);
            tick();
        end
        bus.u_rx_ready = 1'b0;
        chk("t5_drop_sat", bus.drop_cnt, 255);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", bus.mp_valid, 0);
        chk("t5_rst_mode", bus.mp_mode, 0);
        chk("t5_rst_addr", bus.mp_addr, 0);
        chk("t5_rst_wdata", bus.mp_wdata, 0);
        chk("t5_rst_tx_en", bus.u_tx_en, 0);
        chk("t5_rst_tx_data", bus.u_tx_data, 0);
        chk("t5_rst_drop", bus.drop_cnt, 0);
        tick(2);
        rst = 1'b0;
        tick(8);
        chk("t5_no_issue", bus.mp_valid, 0);

`ifdef BB_RD_TIMEOUT_EN
        begin
            bit seen;
            seen = 0;
            send(21'h000555);
            tick();
            ready_pulse();
            for (int i = 0; i < 4 * TMO; i++) begin
                if (bus.u_tx_en === 1'b1) begin
                    seen = 1;
                    break;
                end
                tick();
            end
            chk("t6_tx_en_seen", seen, 1);
            chk("t6_tx_data", bus.u_tx_data, 8'hFF);
            done_pulse(8'h12);
            tick(3);
            chk("t6_late_done", bus.u_tx_data, 8'hFF);
        end
`endif

        tick(2);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
